// File: rtl/color_pkg.sv
// Shared constants, state encoding and small helpers for the color sequencer game.
package color_pkg;

  localparam logic [3:0] COLOR_OFF     = 4'd0;
  localparam logic [3:0] COLOR_RED     = 4'd2;
  localparam logic [3:0] COLOR_CYAN    = 4'd3;
  localparam logic [3:0] COLOR_YELLOW  = 4'd4;
  localparam logic [3:0] COLOR_MAGENTA = 4'd5;

  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW,
    GAP,
    INPUT,
    WIN,
    LOSE
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Only meaningful for a one-hot vector; callers check that first.
  function automatic logic [1:0] btn_code(input logic [3:0] p);
    case (p)
      4'b0010: btn_code = 2'd1;
      4'b0100: btn_code = 2'd2;
      4'b1000: btn_code = 2'd3;
      default: btn_code = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] code_color(input logic [1:0] code);
    code_color = COLOR_RED + {2'b00, code};
  endfunction

endpackage

// File: rtl/btn_sync_pulse.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module btn_sync_pulse #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sync1_q, sync2_q, last_q, pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      last_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      pulse_q <= sync2_q & ~last_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/color_sequencer.sv
// Memory game controller: grows a random color sequence, plays it back, and
// checks the player's button entries against it.
module color_sequencer
  import color_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned SHOW_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] color,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned IDX_W   = $clog2(MAX_LEN);
  // One spare bit so a full 32-entry game can still be compared against MAX_LEN.
  localparam int unsigned LVL_W   = 6;
  localparam int unsigned MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(MAX_LEN);

  logic       start_pulse;
  logic [3:0] btn_pulse;

  btn_sync_pulse #(
    .WIDTH(1)
  ) u_start_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (start),
    .pulse(start_pulse)
  );

  btn_sync_pulse #(
    .WIDTH(4)
  ) u_btn_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (btn),
    .pulse(btn_pulse)
  );

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         seq_q [MAX_LEN];
  logic [1:0]         seq_d [MAX_LEN];
  logic [3:0]         color_q, color_d;
  logic               busy_q, busy_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               last_elem;
  logic               btn_match;

  assign last_elem = (LVL_W'(idx_q) == lvl_q - LVL_W'(1));
  assign btn_match = $onehot(btn_pulse) && (btn_code(btn_pulse) == seq_q[idx_q]);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    seq_d   = seq_q;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start_pulse) begin
          lvl_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        seq_d[lvl_q[IDX_W-1:0]] = lfsr_q[1:0];
        lvl_d   = lvl_q + LVL_W'(1);
        idx_d   = '0;
        timer_d = SHOW_LOAD;
        state_d = SHOW;
      end
      SHOW: begin
        if (timer_q == '0) begin
          timer_d = GAP_LOAD;
          state_d = GAP;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (last_elem) begin
          idx_d   = '0;
          state_d = INPUT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          timer_d = SHOW_LOAD;
          state_d = SHOW;
        end
      end
      INPUT: begin
        if (btn_pulse != 4'b0000) begin
          if (!btn_match) begin
            state_d = LOSE;
          end else if (last_elem) begin
            state_d = (lvl_q == LVL_MAX) ? WIN : ADD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state; seq_d makes a color just
    // appended in ADD visible on the same edge that enters SHOW.
    color_d = (state_d == SHOW) ? code_color(seq_d[idx_d]) : COLOR_OFF;
    busy_d  = (state_d == ADD) || (state_d == SHOW) || (state_d == GAP);
    win_d   = (state_d == WIN);
    lose_d  = (state_d == LOSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      lvl_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      color_q <= COLOR_OFF;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_step(lfsr_q);
      lvl_q   <= lvl_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  // Sequence store is deliberately not reset; only entries below level are read.
  always_ff @(posedge clk) begin
    seq_q <= seq_d;
  end

  assign color = color_q;
  assign level = lvl_q[4:0];
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule
